// File: rtl/mse_loss_backward_pkg.sv
// Shared types, Q16.16 limits and the saturation helper for the MSE backward path.
package mse_bwd_pkg;

    // Fractional bits of the signed Q16.16 data format.
    localparam int FRAC_BITS = 16;

    // Q16.16 extremes used when a result does not fit in 32 bits.
    localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    // Clamp a 65-bit signed value into the 32-bit signed range.
    function automatic logic [31:0] sat32(input logic [64:0] x);
        logic [31:0] r;
        if (x[64:31] == {34{x[64]}}) begin
            r = x[31:0];
        end else if (x[64]) begin
            r = Q_MIN;
        end else begin
            r = Q_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// Registered signed 33x32 fixed-point multiply with arithmetic shift and
// saturation to 32 bits. Holds its output while en_i is low.
module fxp_mul_sat
    import mse_bwd_pkg::*;
#(
    parameter int FRAC = FRAC_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        valid_i,
    input  logic [32:0] a_i,
    input  logic [31:0] b_i,
    output logic        valid_o,
    output logic [31:0] y_o
);

    logic signed [64:0] a_ext_s;
    logic signed [64:0] b_ext_s;
    logic signed [64:0] prod_s;
    logic signed [64:0] shifted_s;
    logic               valid_q;
    logic               valid_d;
    logic [31:0]        y_q;
    logic [31:0]        y_d;

    // Full-precision product; the shift floors toward minus infinity.
    always_comb begin
        a_ext_s   = {{32{a_i[32]}}, a_i};
        b_ext_s   = {{33{b_i[31]}}, b_i};
        prod_s    = a_ext_s * b_ext_s;
        shifted_s = prod_s >>> FRAC;
    end

    // Next-state for the output register: advance only when the pipe moves.
    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        if (en_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                y_d = sat32(shifted_s);
            end else begin
                y_d = y_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Output stage register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            y_q     <= 32'd0;
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
        end
    end

    assign valid_o = valid_q;
    assign y_o     = y_q;

endmodule

// File: rtl/mse_loss_backward.sv
// Streaming MSE loss backward: grad_i = (2*g/N) * (pred_i - target_i), Q16.16.
// Stage 1 registers the 33-bit difference, stage 2 (fxp_mul_sat) scales and
// saturates. A single enable stalls both stages under output backpressure.
module mse_loss_backward
    import mse_bwd_pkg::*;
#(
    parameter int LOG2_N = 4,
    parameter int FRAC   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] grad_scale_in,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [31:0] pred_in,
    input  logic [31:0] target_in,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [31:0] grad_out,
    output logic        last_out,
    output logic        busy,
    output logic        done
);

    localparam logic [LOG2_N:0] N_VAL = {1'b1, {LOG2_N{1'b0}}};
    localparam logic [LOG2_N:0] N_M1  = {1'b0, {LOG2_N{1'b1}}};

    state_e             state_q;
    state_e             state_d;
    logic [LOG2_N:0]    in_cnt_q;
    logic [LOG2_N:0]    in_cnt_d;
    logic [LOG2_N:0]    out_cnt_q;
    logic [LOG2_N:0]    out_cnt_d;
    logic [31:0]        scale_q;
    logic [31:0]        scale_d;
    logic [32:0]        diff_q;
    logic [32:0]        diff_d;
    logic               valid_s1_q;
    logic               valid_s1_d;
    logic               busy_q;
    logic               busy_d;
    logic               done_q;
    logic               done_d;

    logic signed [31:0] g_s;
    logic               en_s;
    logic               in_hs_s;
    logic               out_hs_s;
    logic               last_hs_s;
    logic               valid_s2_s;
    logic [31:0]        grad_s;

    // 2*g/N == g >>> (LOG2_N - 1); LOG2_N == 1 leaves g unshifted.
    assign g_s       = grad_scale_in;
    assign en_s      = !valid_s2_s || ready_out;
    assign ready_in  = (state_q == STREAM) && en_s && (in_cnt_q < N_VAL);
    assign in_hs_s   = valid_in && ready_in;
    assign out_hs_s  = valid_s2_s && ready_out;
    assign last_hs_s = out_hs_s && (out_cnt_q == N_M1);

    // Job FSM, element counters, captured scale and busy/done flags.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        scale_d   = scale_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (out_hs_s) begin
            out_cnt_d = out_cnt_q + {{LOG2_N{1'b0}}, 1'b1};
        end else begin
            out_cnt_d = out_cnt_q;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = STREAM;
                    scale_d   = 32'(g_s >>> (LOG2_N - 1));
                    in_cnt_d  = {(LOG2_N + 1){1'b0}};
                    out_cnt_d = {(LOG2_N + 1){1'b0}};
                    busy_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (in_hs_s) begin
                    in_cnt_d = in_cnt_q + {{LOG2_N{1'b0}}, 1'b1};
                end else begin
                    in_cnt_d = in_cnt_q;
                end
                if (in_cnt_q == N_VAL) begin
                    state_d = DRAIN;
                end else begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                if (last_hs_s) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Stage 1: capture the exact 33-bit difference of each accepted pair.
    always_comb begin
        valid_s1_d = valid_s1_q;
        diff_d     = diff_q;
        if (en_s) begin
            valid_s1_d = in_hs_s;
            if (in_hs_s) begin
                diff_d = {pred_in[31], pred_in} - {target_in[31], target_in};
            end else begin
                diff_d = diff_q;
            end
        end else begin
            valid_s1_d = valid_s1_q;
        end
    end

    // Control and stage-1 registers; reset aborts any job in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_cnt_q   <= {(LOG2_N + 1){1'b0}};
            out_cnt_q  <= {(LOG2_N + 1){1'b0}};
            scale_q    <= 32'd0;
            diff_q     <= 33'd0;
            valid_s1_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            scale_q    <= scale_d;
            diff_q     <= diff_d;
            valid_s1_q <= valid_s1_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    fxp_mul_sat #(
        .FRAC (FRAC)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en_s),
        .valid_i (valid_s1_q),
        .a_i     (diff_q),
        .b_i     (scale_q),
        .valid_o (valid_s2_s),
        .y_o     (grad_s)
    );

    assign valid_out = valid_s2_s;
    assign grad_out  = grad_s;
    assign last_out  = valid_s2_s && (out_cnt_q == N_M1);
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
